// File: rtl/cpu_control_seq.sv
// Fetch/decode/control sequencer feeding the CPU data path; LD/ST go through a dmem handshake.
// Latency (zero-wait acks): ALU 3 cycles, ST 3, LD 4; all outputs registered.
// Backpressure: imem/dmem req holds until ack; TIMEOUT unacked cycles raise bus_err and halt.
module cpu_control_seq #(
    parameter int                  WIDTH    = 32,
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WIDTH-1:0]    imem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WIDTH-1:0]    dmem_addr,
    output logic [WIDTH-1:0]    dmem_wdata,
    input  logic                dmem_ack,
    input  logic [WIDTH-1:0]    dmem_rdata,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic [WIDTH-1:0]    store_data,
    output logic [WIDTH-1:0]    ir_out,
    output logic                dp_wen,
    output logic                reg_file_sel,
    output logic [WIDTH-1:0]    data_out,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                illegal,
    output logic                bus_err
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]      ir_q, ir_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [WIDTH-1:0]      daddr_q, daddr_d;
    logic [WIDTH-1:0]      dwdata_q, dwdata_d;
    logic                  imem_req_q, imem_req_d;
    logic                  dmem_req_q, dmem_req_d;
    logic                  dmem_we_q, dmem_we_d;
    logic                  dp_wen_q, dp_wen_d;
    logic                  sel_q, sel_d;
    logic                  halted_q, halted_d;
    logic                  illegal_q, illegal_d;
    logic                  bus_err_q, bus_err_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            cnt_inc;
    logic                  timeout_hit;

    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == 8'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        data_d     = data_q;
        daddr_d    = daddr_q;
        dwdata_d   = dwdata_q;
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
        dp_wen_d   = 1'b0;
        sel_d      = 1'b0;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_FETCH: begin
                if (imem_req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = S_DECODE;
                end else if (imem_req_q) begin
                    // once raised, the fetch request ignores run until ack or timeout
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        bus_err_d = 1'b1;
                        halted_d  = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        imem_req_d = 1'b1;
                    end
                end else begin
                    imem_req_d = run;
                end
            end
            S_DECODE: begin
                if (!ir_q[31]) begin
                    dp_wen_d = 1'b1;
                    state_d  = S_EXEC;
                end else begin
                    case (ir_q[29:26])
                        OP_LD, OP_ST: begin
                            dmem_req_d = 1'b1;
                            dmem_we_d  = (ir_q[29:26] == OP_ST);
                            daddr_d    = alu_result;
                            dwdata_d   = store_data;
                            cnt_d      = 8'd0;
                            state_d    = S_MEM;
                        end
                        OP_HALT: begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: begin
                            illegal_d  = 1'b1;
                            imem_req_d = run;
                            cnt_d      = 8'd0;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXEC, S_WB: begin
                imem_req_d = run;
                cnt_d      = 8'd0;
                state_d    = S_FETCH;
            end
            S_MEM: begin
                if (dmem_req_q && dmem_ack) begin
                    if (dmem_we_q) begin
                        imem_req_d = run;
                        cnt_d      = 8'd0;
                        state_d    = S_FETCH;
                    end else begin
                        data_d   = dmem_rdata;
                        dp_wen_d = 1'b1;
                        sel_d    = 1'b1;
                        state_d  = S_WB;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        bus_err_d = 1'b1;
                        halted_d  = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        dmem_req_d = 1'b1;
                        dmem_we_d  = dmem_we_q;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            data_q     <= '0;
            daddr_q    <= '0;
            dwdata_q   <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            dp_wen_q   <= 1'b0;
            sel_q      <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            data_q     <= data_d;
            daddr_q    <= daddr_d;
            dwdata_q   <= dwdata_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            dp_wen_q   <= dp_wen_d;
            sel_q      <= sel_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = daddr_q;
    assign dmem_wdata   = dwdata_q;
    assign ir_out       = ir_q;
    assign dp_wen       = dp_wen_q;
    assign reg_file_sel = sel_q;
    assign data_out     = data_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign illegal      = illegal_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_cpu_control_seq.sv
// Randomized bench for cpu_control_seq with an instruction-level reference model.
module tb_cpu_control_seq;
    localparam int          TO  = 15;
    localparam logic [15:0] RPC = 16'hFFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [31:0] alu_result = '0, store_data = '0;
    logic [31:0] ir_out, data_out;
    logic        dp_wen, reg_file_sel, halted, illegal, bus_err;
    logic [15:0] pc;

    cpu_control_seq #(.WIDTH(32), .PC_WIDTH(16), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .alu_result(alu_result), .store_data(store_data),
        .ir_out(ir_out), .dp_wen(dp_wen), .reg_file_sel(reg_file_sel), .data_out(data_out),
        .pc(pc), .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // architectural model state
    logic [15:0] pc_m;
    bit          ill_m, be_m, h_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // kinds: 0 ALU, 1 LD, 2 ST, 3 HALT, 4 illegal
    function automatic logic [31:0] mk(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            0: r[31] = 1'b0;
            1: begin r[31] = 1'b1; r[29:26] = 4'h0; end
            2: begin r[31] = 1'b1; r[29:26] = 4'h1; end
            3: begin r[31] = 1'b1; r[29:26] = 4'hF; end
            default: begin r[31] = 1'b1; r[29:26] = 4'($urandom_range(2, 14)); end
        endcase
        return r;
    endfunction

    function automatic int kind_of(input logic [31:0] i);
        logic [3:0] op;
        op = i[29:26];
        if (!i[31])        return 0;
        if (op == 4'h0)    return 1;
        if (op == 4'h1)    return 2;
        if (op == 4'hF)    return 3;
        return 4;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_dmem_req", 32'(dmem_req), 0);
        check("rst_dmem_we",  32'(dmem_we), 0);
        check("rst_dp_wen",   32'(dp_wen), 0);
        check("rst_sel",      32'(reg_file_sel), 0);
        check("rst_pc",       32'(pc), 32'(RPC));
        check("rst_ir",       ir_out, 0);
        check("rst_data",     data_out, 0);
        check("rst_flags",    32'({halted, illegal, bus_err}), 0);
        pc_m = RPC; ill_m = 0; be_m = 0; h_m = 0;
        imem_ack = 1'b0; dmem_ack = 1'b0; run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Plays imem/dmem for one instruction, then compares against the model.
    task automatic run_instr(input logic [31:0] instr, input int idly, input int ddly,
                             input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rd);
        int          kind = kind_of(instr);
        int          phase = 0, iw = 0, dw = 0, wen_cnt = 0, cyc = 0, dreq_cnt = 0;
        bit          done = 0, sel_bad = 0, dfail;
        logic [31:0] d_addr = '0, d_wdata = '0;
        logic        d_we = 1'b0;
        logic [15:0] pc_before = pc_m;

        imem_rdata = instr; alu_result = alu; store_data = sd; dmem_rdata = rd; run = 1'b1;
        dfail = (ddly >= TO);
        while (!done && cyc < 100) begin
            cyc++;
            if (dp_wen) begin
                wen_cnt++;
                if (reg_file_sel !== (kind == 1)) sel_bad = 1;
            end
            if (dmem_req) begin
                if (dreq_cnt == 0) begin
                    d_addr = dmem_addr; d_wdata = dmem_wdata; d_we = dmem_we;
                end
                dreq_cnt++;
            end
            // stray acks while the request is low must be ignored
            imem_ack = !imem_req && ($urandom_range(0, 3) == 0);
            dmem_ack = !dmem_req && ($urandom_range(0, 3) == 0);
            if (phase == 0) begin
                if (halted) done = 1;
                else if (imem_req) begin
                    if (iw == idly) begin imem_ack = 1'b1; phase = 1; end
                    else iw++;
                    run = ($urandom_range(0, 1) == 1);
                end
            end else begin
                run = 1'b1;
                if (halted || imem_req) done = 1;
                else if (dmem_req) begin
                    if (dw == ddly) dmem_ack = 1'b1;
                    else dw++;
                end
            end
            if (done) begin
                imem_ack = 1'b0; dmem_ack = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("instr_done", 32'(done), 1);

        if (idly >= TO) begin
            be_m = 1; h_m = 1;
            check("itmo_wen", wen_cnt, 0);
        end else begin
            pc_m = pc_m + 16'd1;
            check("ir_out", ir_out, instr);
            if (pc_before == 16'hFFFF) check("pc_wrap", 32'(pc), 0);
            case (kind)
                0: begin
                    check("alu_wen", wen_cnt, 1);
                    check("alu_nodmem", dreq_cnt, 0);
                end
                1, 2: begin
                    check("dmem_addr", d_addr, alu);
                    check("dmem_we", 32'(d_we), 32'(kind == 2));
                    if (kind == 2) check("dmem_wdata", d_wdata, sd);
                    check("dreq_cycles", dreq_cnt, dfail ? TO : ddly + 1);
                    if (dfail) begin
                        be_m = 1; h_m = 1;
                        check("dtmo_wen", wen_cnt, 0);
                    end else if (kind == 1) begin
                        check("ld_data", data_out, rd);
                        check("ld_wen", wen_cnt, 1);
                    end else begin
                        check("st_wen", wen_cnt, 0);
                    end
                end
                3: begin
                    h_m = 1;
                    check("halt_wen", wen_cnt, 0);
                end
                default: begin
                    ill_m = 1;
                    check("ill_wen", wen_cnt, 0);
                    check("ill_nodmem", dreq_cnt, 0);
                end
            endcase
            check("wen_sel", 32'(sel_bad), 0);
        end
        check("pc", 32'(pc), 32'(pc_m));
        check("halted", 32'(halted), 32'(h_m));
        check("illegal", 32'(illegal), 32'(ill_m));
        check("bus_err", 32'(bus_err), 32'(be_m));
    endtask

    task automatic check_frozen();
        int reqs = 0;
        run = 1'b1;
        repeat (10) begin
            imem_ack = 1'b1; dmem_ack = 1'b1;
            @(negedge clk);
            if (imem_req || dmem_req || dp_wen) reqs++;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        check("halt_noreq", reqs, 0);
        check("halt_pc", 32'(pc), 32'(pc_m));
        check("halt_flag", 32'(halted), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, id, dd;
        repeat (2) @(negedge clk);
        do_reset();

        run_instr(32'h00A41800, 0, 0, $urandom, $urandom, $urandom);
        run_instr(32'h80A40004, 0, 0, 32'h10, $urandom, 32'hDEADBEEF);
        run_instr(32'h84A40000, 0, 0, $urandom, 32'h1234, $urandom);
        run_instr(32'h88000000, 0, 0, $urandom, $urandom, $urandom);
        run_instr(mk(0), 0, 0, $urandom, $urandom, $urandom);
        run_instr(mk(0), TO - 1, 0, $urandom, $urandom, $urandom);
        run_instr(mk(1), 0, TO - 1, $urandom, $urandom, $urandom);
        run_instr(mk(2), 2, TO - 1, $urandom, $urandom, $urandom);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 3);
            if (k == 3) k = 4;
            run_instr(mk(k), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom, $urandom, $urandom);
        end

        // reset while the next fetch request is pending
        do_reset();
        run_instr(mk(1), 1, 1, $urandom, $urandom, $urandom);

        run_instr(32'hBC000000, 0, 0, $urandom, $urandom, $urandom);
        check_frozen();
        do_reset();

        run_instr(mk(0), TO, 0, $urandom, $urandom, $urandom);
        check_frozen();
        do_reset();

        run_instr(mk(1), 0, TO, $urandom, $urandom, $urandom);
        check_frozen();
        do_reset();

        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 4);
            id = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, 4);
            dd = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 4);
            run_instr(mk(k), id, dd, $urandom, $urandom, $urandom);
            if (h_m) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
